// File: rtl/seq_chunk_adder_if.sv
// -----------------------------------------------------------------------------
// seq_chunk_adder_if
//   Handshake bundle for seq_chunk_adder: an operand channel (in_*) and a
//   result channel (out_*), each with its own valid/ready pair.
//   Port summary:
//     in_valid / in_ready       operand handshake (source -> adder)
//     in_x, in_y                operands, WIDTH bits
//     in_cin                    carry-in (ignored when in_sub=1)
//     in_sub                    1: X - Y, 0: X + Y + cin
//     out_valid / out_ready     result handshake (adder -> sink)
//     out_s                     sum/difference, WIDTH bits
//     out_cout                  carry out of MSB (sub mode: 1 = no borrow)
//     out_ovf                   signed overflow
//   Modports:
//     master  - the environment that drives operands and accepts results
//     slave   - the adder itself
// -----------------------------------------------------------------------------
interface seq_chunk_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_x;
    logic [WIDTH-1:0] in_y;
    logic             in_cin;
    logic             in_sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_s;
    logic             out_cout;
    logic             out_ovf;

    modport master (
        output in_valid, in_x, in_y, in_cin, in_sub, out_ready,
        input  in_ready, out_valid, out_s, out_cout, out_ovf
    );

    modport slave (
        input  in_valid, in_x, in_y, in_cin, in_sub, out_ready,
        output in_ready, out_valid, out_s, out_cout, out_ovf
    );
endinterface

// File: rtl/seq_chunk_adder.sv
// -----------------------------------------------------------------------------
// seq_chunk_adder
//   Multi-cycle adder/subtractor. One CHUNK-bit slice is added per clock and
//   the inter-slice carry is kept in a register, so a WIDTH-bit operation takes
//   NCHUNK = WIDTH/CHUNK cycles instead of one long ripple path.
//   FSM: IDLE (accept operands) -> RUN (NCHUNK slice cycles) -> DONE (hold
//   result until accepted) -> IDLE.
//
//   Ports:
//     clk     rising-edge clock
//     rst_n   asynchronous active-low reset
//     bus     seq_chunk_adder_if.slave (operand and result handshakes)
//
//   Parameters:
//     WIDTH   operand/result width (>= 2)
//     CHUNK   bits added per cycle (WIDTH % CHUNK == 0)
//
//   Optional feature macro: SEQ_CHUNK_ADDER_SAT_EN
//     defined   -> on signed overflow out_s saturates to 0x7F..F / 0x80..0
//     undefined -> out_s wraps modulo 2^WIDTH, no saturation logic
//   out_cout and out_ovf are reported identically in both builds.
// -----------------------------------------------------------------------------
module seq_chunk_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    seq_chunk_adder_if.slave    bus
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    generate
        if (WIDTH < 2) begin : g_bad_width
            $error("seq_chunk_adder: WIDTH must be >= 2");
        end
        if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_chunk
            $error("seq_chunk_adder: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] x_q;
    logic [WIDTH-1:0] y_q;          // already inverted in subtract mode
    logic             carry_q;
    logic [IDXW-1:0]  idx_q;
    logic [WIDTH-1:0] s_q;
    logic             cout_q;
    logic             ovf_q;

    logic             accept;
    logic             last_slice;
    int               base;
    logic [CHUNK-1:0] x_sl;
    logic [CHUNK-1:0] y_sl;
    logic [CHUNK:0]   slice_sum;
    logic             c_into_msb;
    logic             ovf_now;

`ifdef SEQ_CHUNK_ADDER_SAT_EN
    // Overflow can only happen when both effective operand MSBs match, so the
    // shared MSB picks the rail: 0 -> most positive, 1 -> most negative.
    function automatic logic [WIDTH-1:0] sat_value(input logic msb);
        sat_value = {msb, {(WIDTH-1){~msb}}};
    endfunction
`endif

    assign accept     = (state_q == IDLE) && bus.in_valid;
    assign last_slice = (idx_q == LAST_IDX);

    // Slice adder on the current chunk
    always_comb begin
        base      = int'(idx_q) * CHUNK;
        x_sl      = x_q[base +: CHUNK];
        y_sl      = y_q[base +: CHUNK];
        slice_sum = {1'b0, x_sl} + {1'b0, y_sl} + {{CHUNK{1'b0}}, carry_q};
        // Sum bit = a ^ b ^ cin, so the carry into the top bit of the slice is
        // recovered without a separate (CHUNK-1)-bit adder; works for CHUNK=1.
        c_into_msb = slice_sum[CHUNK-1] ^ x_sl[CHUNK-1] ^ y_sl[CHUNK-1];
        ovf_now    = c_into_msb ^ slice_sum[CHUNK];
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = RUN;
            RUN:     if (last_slice) state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand capture and slice-by-slice accumulation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q     <= '0;
            y_q     <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        x_q     <= bus.in_x;
                        y_q     <= bus.in_sub ? ~bus.in_y : bus.in_y;
                        carry_q <= bus.in_sub ? 1'b1 : bus.in_cin;
                        idx_q   <= '0;
                    end
                end
                RUN: begin
                    s_q[base +: CHUNK] <= slice_sum[CHUNK-1:0];
                    carry_q            <= slice_sum[CHUNK];
                    idx_q              <= idx_q + 1'b1;
                    if (last_slice) begin
                        cout_q <= slice_sum[CHUNK];
                        ovf_q  <= ovf_now;
`ifdef SEQ_CHUNK_ADDER_SAT_EN
                        if (ovf_now) begin
                            s_q <= sat_value(x_q[WIDTH-1]);
                        end
`endif
                    end
                end
                default: ;  // DONE: result registers hold under backpressure
            endcase
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_s     = s_q;
    assign bus.out_cout  = cout_q;
    assign bus.out_ovf   = ovf_q;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// -----------------------------------------------------------------------------
// tb_seq_chunk_adder
//   Directed bench for seq_chunk_adder at WIDTH=16, CHUNK=4 (4 slice cycles).
//   Expected values are hand-computed constants per vector.
// -----------------------------------------------------------------------------
module tb_seq_chunk_adder;
    localparam int W = 16;

    logic clk;
    logic rst_n;
    int   tests_run;
    int   tests_failed;

    seq_chunk_adder_if #(.WIDTH(W)) bus ();

    seq_chunk_adder #(.WIDTH(W), .CHUNK(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands and wait (bounded) for the accepting edge.
    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic cin, input logic sub, input string tag);
        int n;
        bus.in_x     = x;
        bus.in_y     = y;
        bus.in_cin   = cin;
        bus.in_sub   = sub;
        bus.in_valid = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 20) begin
            tick();
            n++;
        end
        if (!bus.in_ready) check_eq({tag, "_ready_timeout"}, 32'(bus.in_ready), 32'd1);
        tick();                     // acceptance edge E0
        bus.in_valid = 1'b0;
        check_eq({tag, "_busy"}, 32'(bus.in_ready), 32'd0);
    endtask

    // Wait for out_valid, counting edges after E0.
    task automatic wait_result(input string tag);
        int n;
        n = 0;
        while (!bus.out_valid && n < 20) begin
            tick();
            n++;
        end
        check_eq({tag, "_latency"}, 32'(n), 32'd4);
    endtask

    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic cin, input logic sub,
                          input logic [W-1:0] es, input logic ec, input logic eo,
                          input string tag);
        issue(x, y, cin, sub, tag);
        wait_result(tag);
        check_eq({tag, "_s"},    32'(bus.out_s),    32'(es));
        check_eq({tag, "_cout"}, 32'(bus.out_cout), 32'(ec));
        check_eq({tag, "_ovf"},  32'(bus.out_ovf),  32'(eo));
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check_eq({tag, "_vld_drop"}, 32'(bus.out_valid), 32'd0);
        check_eq({tag, "_idle"},     32'(bus.in_ready),  32'd1);
    endtask

    logic [W-1:0] s_pos_ovf;
    logic [W-1:0] s_neg_ovf;
    logic [W-1:0] s_sub_ovf;
    logic [W-1:0] held_s;

    initial begin
`ifdef SEQ_CHUNK_ADDER_SAT_EN
        s_pos_ovf = 16'h7FFF;
        s_neg_ovf = 16'h8000;
        s_sub_ovf = 16'h8000;
`else
        s_pos_ovf = 16'h8000;
        s_neg_ovf = 16'h0000;
        s_sub_ovf = 16'h7FFF;
`endif
        tests_run     = 0;
        tests_failed  = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_x      = '0;
        bus.in_y      = '0;
        bus.in_cin    = 1'b0;
        bus.in_sub    = 1'b0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("rst_in_ready",  32'(bus.in_ready),  32'd1);
        check_eq("rst_s",         32'(bus.out_s),     32'd0);
        check_eq("rst_cout",      32'(bus.out_cout),  32'd0);
        check_eq("rst_ovf",       32'(bus.out_ovf),   32'd0);
        rst_n = 1'b1;
        tick();

        // x, y, cin, sub, S, cout, ovf
        run_op(16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, "add_1_1");
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, "ripple_all");
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, s_pos_ovf, 1'b0, 1'b1, "pos_ovf");
        run_op(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, "sub_neg");
        run_op(16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0, "sub_pos");
        run_op(16'h1234, 16'h0FFF, 1'b1, 1'b0, 16'h2234, 1'b0, 1'b0, "add_cin");
        run_op(16'h8000, 16'h8000, 1'b0, 1'b0, s_neg_ovf, 1'b1, 1'b1, "neg_ovf");
        run_op(16'h8000, 16'h0001, 1'b0, 1'b1, s_sub_ovf, 1'b1, 1'b1, "sub_ovf");

        // Backpressure: result held for 5 cycles, new operands ignored
        issue(16'h00F0, 16'h0F0F, 1'b0, 1'b0, "bp");
        wait_result("bp");
        held_s = bus.out_s;
        check_eq("bp_s", 32'(held_s), 32'h0FFF);
        bus.in_x     = 16'hAAAA;
        bus.in_y     = 16'h5555;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("bp_valid_hold", 32'(bus.out_valid), 32'd1);
            check_eq("bp_s_hold",     32'(bus.out_s),     32'h0FFF);
            check_eq("bp_cout_hold",  32'(bus.out_cout),  32'd0);
            check_eq("bp_ovf_hold",   32'(bus.out_ovf),   32'd0);
            check_eq("bp_in_ready",   32'(bus.in_ready),  32'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check_eq("bp_release_valid", 32'(bus.out_valid), 32'd0);
        check_eq("bp_release_ready", 32'(bus.in_ready),  32'd1);
        tick();
        check_eq("bp_no_accept", 32'(bus.in_ready), 32'd1);

        // Reset in the 2nd RUN cycle: first slice already written, then discarded
        issue(16'h1111, 16'h2222, 1'b0, 1'b0, "rst_mid");
        tick();                     // now in 2nd RUN cycle
        rst_n = 1'b0;
        #1;
        check_eq("rst_mid_valid", 32'(bus.out_valid), 32'd0);
        check_eq("rst_mid_s",     32'(bus.out_s),     32'd0);
        check_eq("rst_mid_cout",  32'(bus.out_cout),  32'd0);
        check_eq("rst_mid_ovf",   32'(bus.out_ovf),   32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check_eq("rst_mid_ready", 32'(bus.in_ready),  32'd1);
        check_eq("rst_mid_novld", 32'(bus.out_valid), 32'd0);
        run_op(16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0, "after_rst");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Absolute time bound so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: sim time exceeded bound, tests_failed=%0d", tests_failed);
        $fatal(1, "timeout");
    end
endmodule
